// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Launch sequencer states for the transmit front-end
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO with registered occupancy count.
// Latency: a write is visible on rd_dat the cycle after wr_en; rd_dat shows the head combinationally.
// Backpressure: writes while full and reads while empty are ignored internally.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_dat,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_dat,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  // The extra pointer MSB tells a full ring apart from an empty one
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_dat  = mem[rd_ptr[ADDR_W-1:0]];

  // Storage array; contents deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_dat;
    end
  end

  // Pointer advance and occupancy count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (rd_fire) rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      case ({wr_fire, rd_fire})
        2'b10:   level <= level + (ADDR_W+1)'(1);
        2'b01:   level <= level - (ADDR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Purpose: buffers host bytes and launches them one at a time into the UART transmitter.
// Latency: byte pushed into an idle, empty queue shows on tx_start/tx_data two cycles later.
// Backpressure: in_ready drops when full; a push while full is dropped and flags overflow.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [UART_DATA_W-1:0] in_data,
  output logic                   in_ready,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic [ADDR_W:0]        level,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT);

  tx_state_t              state;
  logic [TMR_W-1:0]       timer;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] head_dat;
  logic                   pop_en;

  assign in_ready = !fifo_full;

  // Pop only when leaving IDLE, so the FIFO head is consumed exactly once per launch
  assign pop_en = (state == IDLE) && !fifo_empty && !tx_busy;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (UART_DATA_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (in_valid),
    .wr_dat (in_data),
    .rd_en  (pop_en),
    .rd_dat (head_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level)
  );

  // Sticky overflow; a fresh overflow wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (in_valid && fifo_full) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Launch sequencer: pop, pulse tx_start, wait for the UART to acknowledge and finish
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      timer    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop_en) begin
            tx_data  <= head_dat;
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tx_start <= 1'b0;
          timer    <= TMR_LOAD;
          state    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // No acknowledge within the window: the byte is abandoned, never re-sent
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else begin
            timer <= timer - TMR_W'(1);
            if (timer <= TMR_W'(1)) state <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
